// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC arbiter: opcodes, arbiter state encoding and widths.
package cordic_pkg;

   localparam int OPND_W = 32;
   localparam int RES_W  = 64;
   localparam int OP_W   = 3;

   localparam logic [OP_W-1:0] OP_SIN_COS  = 3'd0;
   localparam logic [OP_W-1:0] OP_ATAN2    = 3'd1;
   localparam logic [OP_W-1:0] OP_SQRT_MAG = 3'd2;
   localparam logic [OP_W-1:0] OP_MULT     = 3'd3;

   localparam logic [2:0] ST_IDLE    = 3'd0;
   localparam logic [2:0] ST_ISSUE   = 3'd1;
   localparam logic [2:0] ST_WAIT    = 3'd2;
   localparam logic [2:0] ST_COLLECT = 3'd3;
   localparam logic [2:0] ST_RESPOND = 3'd4;

   function automatic logic op_is_valid(input logic [OP_W-1:0] op);
      return op <= OP_MULT;
   endfunction

endpackage

// File: rtl/cordic_arbiter_if.sv
// Requester and core-facing signal bundle of the CORDIC arbiter; master is the arbiter side.
interface cordic_arbiter_if import cordic_pkg::*; #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]        req_valid;
   logic [NREQ-1:0]        req_ready;
   logic [OP_W*NREQ-1:0]   req_op;
   logic [OPND_W*NREQ-1:0] req_a;
   logic [OPND_W*NREQ-1:0] req_b;
   logic [NREQ-1:0]        rsp_valid;
   logic [RES_W-1:0]       rsp_data;
   logic                   rsp_err;
   logic [OP_W-1:0]        core_op;
   logic [OPND_W-1:0]      core_a;
   logic [OPND_W-1:0]      core_b;
   logic                   core_start;
   logic                   core_start_rdy;
   logic                   core_busy;
   logic                   core_res_rdy;
   logic [RES_W-1:0]       core_res;
   logic                   core_res_take;

   modport master (
      input  req_valid, req_op, req_a, req_b,
      input  core_start_rdy, core_busy, core_res_rdy, core_res,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output core_op, core_a, core_b, core_start, core_res_take
   );

   modport slave (
      output req_valid, req_op, req_a, req_b,
      output core_start_rdy, core_busy, core_res_rdy, core_res,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  core_op, core_a, core_b, core_start, core_res_take
   );
endinterface

// File: rtl/cordic_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit at or above ptr, wrapping to 0.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] valid,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   idx
);
   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   logic              found;
   int                pos;

   // rot[k] is requester (ptr+k) mod NREQ
   assign dbl = {valid, valid} >> ptr;
   assign rot = dbl[NREQ-1:0];

   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = 0;
      for (int k = 0; k < NREQ; k++) begin
         if (!found && rot[k]) begin
            found = 1'b1;
            pos   = int'(ptr) + k;
            if (pos >= NREQ) pos = pos - NREQ;
            idx   = IW'(pos);
         end
      end
   end

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_grant
      assign grant[gi] = found && (idx == IW'(gi));
   end
endmodule

// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one CORDIC core among NREQ requesters, one op in flight.
// Define CORDIC_ARB_TIMEOUT_EN to add an ISSUE/WAIT watchdog of TIMEOUT_CYCLES cycles.
module cordic_arbiter import cordic_pkg::*; #(
   parameter int NREQ           = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             rst,
   cordic_arbiter_if.master bus
);
   localparam int IW = $clog2(NREQ);

   logic [2:0]        state_reg, state_next;
   logic [IW-1:0]     ptr_reg, gidx_reg, pick_idx;
   logic [NREQ-1:0]   pick_grant, ready_vec, rsp_vec;
   logic [OP_W-1:0]   op_reg, sel_op;
   logic [OPND_W-1:0] a_reg, b_reg;
   logic [RES_W-1:0]  data_reg;
   logic              err_reg, accept, start_strobe, take_strobe;

`ifdef CORDIC_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] cnt_reg;
   logic          timeout;
   assign timeout = (cnt_reg == TW'(TIMEOUT_CYCLES - 1));
`endif

   rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
      .valid (bus.req_valid),
      .ptr   (ptr_reg),
      .grant (pick_grant),
      .idx   (pick_idx)
   );

   assign sel_op = bus.req_op[int'(pick_idx)*OP_W +: OP_W];

   always_comb begin
      state_next   = state_reg;
      ready_vec    = '0;
      accept       = 1'b0;
      start_strobe = 1'b0;
      take_strobe  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (|pick_grant) begin
               ready_vec  = pick_grant;
               accept     = 1'b1;
               state_next = op_is_valid(sel_op) ? ST_ISSUE : ST_RESPOND;
            end
         end
         ST_ISSUE: begin
            start_strobe = bus.core_start_rdy;
            if (bus.core_start_rdy) state_next = ST_WAIT;
`ifdef CORDIC_ARB_TIMEOUT_EN
            else if (timeout) state_next = ST_RESPOND;
`endif
         end
         ST_WAIT: begin
            if (bus.core_res_rdy && !bus.core_busy) state_next = ST_COLLECT;
`ifdef CORDIC_ARB_TIMEOUT_EN
            else if (timeout) state_next = ST_RESPOND;
`endif
         end
         ST_COLLECT: begin
            take_strobe = 1'b1;
            state_next  = ST_RESPOND;
         end
         ST_RESPOND: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
         ptr_reg   <= '0;
         gidx_reg  <= '0;
         op_reg    <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         data_reg  <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            op_reg   <= sel_op;
            a_reg    <= bus.req_a[int'(pick_idx)*OPND_W +: OPND_W];
            b_reg    <= bus.req_b[int'(pick_idx)*OPND_W +: OPND_W];
            gidx_reg <= pick_idx;
            if (!op_is_valid(sel_op)) begin
               data_reg <= '0;
               err_reg  <= 1'b1;
            end
         end
         if (state_reg == ST_COLLECT) begin
            // only sin_cos returns a full 64-bit pair; the rest are 32-bit scalars
            data_reg <= (op_reg == OP_SIN_COS) ? bus.core_res
                                               : {32'b0, bus.core_res[31:0]};
            err_reg  <= 1'b0;
         end
`ifdef CORDIC_ARB_TIMEOUT_EN
         if ((state_reg == ST_ISSUE || state_reg == ST_WAIT) && state_next == ST_RESPOND) begin
            data_reg <= '0;
            err_reg  <= 1'b1;
         end
`endif
         if (state_reg == ST_RESPOND)
            ptr_reg <= (gidx_reg == IW'(NREQ - 1)) ? '0 : gidx_reg + IW'(1);
      end
   end

`ifdef CORDIC_ARB_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_reg <= '0;
      else if (accept)
         cnt_reg <= '0;
      else if (state_reg == ST_ISSUE || state_reg == ST_WAIT)
         cnt_reg <= cnt_reg + TW'(1);
   end
`endif

   for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
      assign rsp_vec[gi] = (state_reg == ST_RESPOND) && (gidx_reg == IW'(gi));
   end

   // the grant search sees req_valid even while reset is held, so mask it there
   assign bus.req_ready     = rst ? '0 : ready_vec;
   assign bus.rsp_valid     = rsp_vec;
   assign bus.rsp_data      = data_reg;
   assign bus.rsp_err       = err_reg;
   assign bus.core_op       = op_reg;
   assign bus.core_a        = a_reg;
   assign bus.core_b        = b_reg;
   assign bus.core_start    = start_strobe;
   assign bus.core_res_take = take_strobe;
endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter with a small behavioural CORDIC core model.
module tb_cordic_arbiter;
   localparam int NREQ = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cordic_arbiter_if #(.NREQ(NREQ)) bus ();

   cordic_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(20)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // core model controls
   logic        start_rdy_en = 1'b1;
   logic        core_hang    = 1'b0;
   int          core_delay   = 0;
   logic [63:0] core_result  = '0;
   logic        m_busy, m_rdy;
   int          m_cnt;

   assign bus.core_start_rdy = start_rdy_en;
   assign bus.core_busy      = m_busy;
   assign bus.core_res_rdy   = m_rdy;
   assign bus.core_res       = core_result;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_rdy  <= 1'b0;
         m_cnt  <= 0;
      end else begin
         if (bus.core_res_take) m_rdy <= 1'b0;
         if (bus.core_start) begin
            m_rdy <= 1'b0;
            if (core_hang) begin
               m_busy <= 1'b1;
            end else if (core_delay == 0) begin
               m_busy <= 1'b0;
               m_rdy  <= 1'b1;
            end else begin
               m_busy <= 1'b1;
               m_cnt  <= core_delay;
            end
         end else if (m_busy && !core_hang) begin
            if (m_cnt <= 1) begin
               m_busy <= 1'b0;
               m_rdy  <= 1'b1;
            end else begin
               m_cnt <= m_cnt - 1;
            end
         end
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   // monitor: samples on the falling edge
   int              acc_idx_q[$];
   int              acc_cyc_q[$];
   logic [NREQ-1:0] rsp_vec_q[$];
   logic [63:0]     rsp_data_q[$];
   logic            rsp_err_q[$];
   int              rsp_cyc_q[$];
   int              start_cnt = 0;
   int              take_cnt  = 0;
   int              last_start_cyc = 0;

   always @(negedge clk) begin
      if (!rst) begin
         if ((bus.req_valid & bus.req_ready) != '0) begin
            for (int i = 0; i < NREQ; i++) begin
               if (bus.req_ready[i]) begin
                  acc_idx_q.push_back(i);
                  acc_cyc_q.push_back(cyc);
               end
            end
         end
         if (bus.rsp_valid != '0) begin
            rsp_vec_q.push_back(bus.rsp_valid);
            rsp_data_q.push_back(bus.rsp_data);
            rsp_err_q.push_back(bus.rsp_err);
            rsp_cyc_q.push_back(cyc);
         end
         if (bus.core_start) begin
            start_cnt      <= start_cnt + 1;
            last_start_cyc <= cyc;
         end
         if (bus.core_res_take) take_cnt <= take_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input int idx, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
      int n0;
      bit got;
      n0  = acc_idx_q.size();
      got = 1'b0;
      bus.req_op[idx*3 +: 3]   = op;
      bus.req_a[idx*32 +: 32]  = a;
      bus.req_b[idx*32 +: 32]  = b;
      bus.req_valid[idx]       = 1'b1;
      for (int k = 0; k < 50 && !got; k++) begin
         tick(1);
         if (acc_idx_q.size() > n0) got = 1'b1;
      end
      bus.req_valid[idx] = 1'b0;
      chk("accepted", 64'(got), 64'd1);
   endtask

   task automatic wait_rsp(input int n);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 200 && !got; k++) begin
         if (rsp_vec_q.size() >= n) got = 1'b1;
         else tick(1);
      end
      chk("rsp_arrived", 64'(got), 64'd1);
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.req_valid = '0;
      tick(2);
      rst = 1'b0;
      tick(1);
   endtask

   int s0, t0, r0, base;
   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      bus.req_valid = '0;
      bus.req_op    = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;

      // reset state, with all requesters pending while reset is held
      tick(1);
      bus.req_valid = 4'hF;
      #1;
      chk("rst_req_ready", 64'(bus.req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
      chk("rst_rsp_data",  bus.rsp_data, 64'h0);
      chk("rst_rsp_err",   64'(bus.rsp_err), 64'h0);
      chk("rst_core_start", 64'(bus.core_start), 64'h0);
      chk("rst_core_take", 64'(bus.core_res_take), 64'h0);
      chk("rst_core_op_a", {29'b0, bus.core_op, bus.core_a}, 64'h0);
      do_reset();

      // single sin_cos, core answers three cycles after start
      core_delay  = 3;
      core_result = 64'h1111_2222_3333_4444;
      s0 = start_cnt; t0 = take_cnt; r0 = rsp_vec_q.size();
      send(0, 3'd0, 32'h0000_4000, 32'h0);
      chk("sc_core_a", 64'(bus.core_a), 64'h4000);
      wait_rsp(r0 + 1);
      chk("sc_rsp_valid", 64'(rsp_vec_q[r0]), 64'h1);
      chk("sc_rsp_data", rsp_data_q[r0], 64'h1111_2222_3333_4444);
      chk("sc_rsp_err", 64'(rsp_err_q[r0]), 64'h0);
      chk("sc_starts", 64'(start_cnt - s0), 64'd1);
      chk("sc_takes", 64'(take_cnt - t0), 64'd1);

      // instant core, multiply from req1: upper half cleared, response 4 cycles after accept
      core_delay  = 0;
      core_result = 64'hDEAD_BEEF_0000_1234;
      r0 = rsp_vec_q.size(); base = acc_cyc_q.size();
      send(1, 3'd3, 32'h7, 32'h9);
      wait_rsp(r0 + 1);
      chk("mul_rsp_valid", 64'(rsp_vec_q[r0]), 64'h2);
      chk("mul_rsp_data", rsp_data_q[r0], 64'h0000_0000_0000_1234);
      chk("mul_latency", 64'(rsp_cyc_q[r0] - acc_cyc_q[base]), 64'd4);

      // invalid opcode from req2: no core start, error response one cycle after accept
      s0 = start_cnt; r0 = rsp_vec_q.size(); base = acc_cyc_q.size();
      send(2, 3'd5, 32'hAAAA, 32'hBBBB);
      wait_rsp(r0 + 1);
      chk("inv_rsp_valid", 64'(rsp_vec_q[r0]), 64'h4);
      chk("inv_rsp_err", 64'(rsp_err_q[r0]), 64'h1);
      chk("inv_rsp_data", rsp_data_q[r0], 64'h0);
      chk("inv_latency", 64'(rsp_cyc_q[r0] - acc_cyc_q[base]), 64'd1);
      chk("inv_starts", 64'(start_cnt - s0), 64'd0);
      tick(5);
      chk("inv_err_hold", 64'(bus.rsp_err), 64'h1);
      chk("inv_rsp_idle", 64'(bus.rsp_valid), 64'h0);

      // start stall: core not ready for 10 cycles
      start_rdy_en = 1'b0;
      core_delay   = 2;
      core_result  = 64'hAAAA_BBBB_0001_0000;
      s0 = start_cnt; r0 = rsp_vec_q.size();
      send(3, 3'd2, 32'h3, 32'h4);
      tick(10);
      chk("stall_starts", 64'(start_cnt - s0), 64'd0);
      chk("stall_core_start", 64'(bus.core_start), 64'h0);
      start_rdy_en = 1'b1;
      base = cyc;
      tick(1);
      chk("stall_start_cnt", 64'(start_cnt - s0), 64'd1);
      chk("stall_start_cyc", 64'(last_start_cyc), 64'(base));
      wait_rsp(r0 + 1);
      chk("stall_rsp_valid", 64'(rsp_vec_q[r0]), 64'h8);
      chk("stall_rsp_data", rsp_data_q[r0], 64'h0000_0000_0001_0000);

      // reset while the core is busy
      core_delay = 20;
      r0 = rsp_vec_q.size();
      send(0, 3'd1, 32'h1234_5678, 32'h9);
      tick(3);
      chk("mid_core_a_live", 64'(bus.core_a), 64'h1234_5678);
      rst = 1'b1;
      #1;
      chk("mid_core_a", 64'(bus.core_a), 64'h0);
      chk("mid_core_op", 64'(bus.core_op), 64'h0);
      chk("mid_rsp_data", bus.rsp_data, 64'h0);
      chk("mid_take_start", {62'b0, bus.core_res_take, bus.core_start}, 64'h0);
      tick(2);
      rst = 1'b0;
      tick(5);
      chk("mid_no_rsp", 64'(rsp_vec_q.size()), 64'(r0));
      core_delay  = 0;
      core_result = 64'h0BAD_F00D_5555_6666;
      base = acc_idx_q.size();
      send(1, 3'd3, 32'h1, 32'h2);
      chk("post_rst_grant", 64'(acc_idx_q[base]), 64'd1);
      wait_rsp(r0 + 1);
      chk("post_rst_rsp_valid", 64'(rsp_vec_q[r0]), 64'h2);
      chk("post_rst_rsp_data", rsp_data_q[r0], 64'h0000_0000_5555_6666);

      // contention: all four requesters hold multiply requests
      do_reset();
      core_delay  = 1;
      core_result = 64'hFFFF_FFFF_8765_4321;
      for (int i = 0; i < NREQ; i++) begin
         bus.req_op[i*3 +: 3]  = 3'd3;
         bus.req_a[i*32 +: 32] = 32'(i + 1);
         bus.req_b[i*32 +: 32] = 32'h10;
      end
      base = acc_idx_q.size(); r0 = rsp_vec_q.size();
      bus.req_valid = 4'hF;
      for (int k = 0; k < 200 && acc_idx_q.size() < base + 5; k++) tick(1);
      bus.req_valid = '0;
      chk("cont_accepts", 64'(acc_idx_q.size() - base), 64'd5);
      wait_rsp(r0 + 5);
      for (int k = 0; k < 5; k++) begin
         if (acc_idx_q.size() > base + k && rsp_vec_q.size() > r0 + k) begin
            chk($sformatf("cont_grant%0d", k), 64'(acc_idx_q[base+k]), 64'(exp_order[k]));
            chk($sformatf("cont_rsp_valid%0d", k), 64'(rsp_vec_q[r0+k]), 64'(1 << exp_order[k]));
            chk($sformatf("cont_rsp_data%0d", k), rsp_data_q[r0+k], 64'h0000_0000_8765_4321);
         end
      end

`ifdef CORDIC_ARB_TIMEOUT_EN
      // watchdog: the core never produces a result
      core_hang = 1'b1;
      t0 = take_cnt; r0 = rsp_vec_q.size(); base = acc_cyc_q.size();
      send(2, 3'd0, 32'h1, 32'h0);
      wait_rsp(r0 + 1);
      chk("to_rsp_err", 64'(rsp_err_q[r0]), 64'h1);
      chk("to_rsp_data", rsp_data_q[r0], 64'h0);
      chk("to_latency", 64'(rsp_cyc_q[r0] - acc_cyc_q[base] - 1), 64'd20);
      chk("to_takes", 64'(take_cnt - t0), 64'd0);
      core_hang   = 1'b0;
      core_delay  = 0;
      core_result = 64'h0123_4567_89AB_CDEF;
      r0 = rsp_vec_q.size();
      send(3, 3'd0, 32'h2, 32'h0);
      wait_rsp(r0 + 1);
      chk("to_next_err", 64'(rsp_err_q[r0]), 64'h0);
      chk("to_next_data", rsp_data_q[r0], 64'h0123_4567_89AB_CDEF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
